// File: rtl/hidden_layer_sequencer.sv
// hidden_layer_sequencer
// Runs one inference pass through a hidden layer: captures an input vector on
// START, streams it element by element into the layer's serial port, waits
// (bounded) for every neuron to report valid, latches the outputs and pulses
// DONE. Overflow and timeout status stay readable until the next pass starts.
module hidden_layer_sequencer #(
    parameter int NUM_INPUTS     = 4,
    parameter int NUM_OUTPUTS    = 4,
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                           CLK,
    input  logic                           RSTN,
    input  logic                           START,
    input  logic [NUM_INPUTS*WIDTH-1:0]    VALUES_IN,
    output logic                           BUSY,
    output logic                           DONE,
    output logic [NUM_OUTPUTS*WIDTH-1:0]   RESULTS,
    output logic                           OVERFLOW,
    output logic                           TIMEOUT,
    input  logic                           LAYER_READY,
    output logic [WIDTH-1:0]               LAYER_VALUE,
    output logic                           LAYER_VALID,
    input  logic [NUM_OUTPUTS*WIDTH-1:0]   LAYER_VALUES,
    input  logic [NUM_OUTPUTS-1:0]         LAYER_VALIDS,
    input  logic                           LAYER_OVERFLOW
);

    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_INPUTS - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t                         state_q, state_d;
    logic [NUM_INPUTS*WIDTH-1:0]    buf_q, buf_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [NUM_OUTPUTS*WIDTH-1:0]   results_q, results_d;
    logic                           overflow_q, overflow_d;
    logic                           timeout_q, timeout_d;
    logic                           layer_valid;
    logic [WIDTH-1:0]               layer_value;

    // State and datapath registers; everything clears on asynchronous reset.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= S_IDLE;
            // NOTE: the input buffer is a plain register vector, so clearing it
            // on reset is cheap; nothing from an aborted pass survives reset.
            buf_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            results_q  <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from
            // the same pre-edge values, independent of statement order.
            state_q    <= state_d;
            buf_q      <= buf_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            results_q  <= results_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic plus the layer-facing strobe and data.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        buf_d       = buf_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        results_d   = results_q;
        overflow_d  = overflow_q;
        timeout_d   = timeout_q;
        layer_valid = 1'b0;
        layer_value = '0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    buf_d      = VALUES_IN;
                    idx_d      = '0;
                    cnt_d      = '0;
                    overflow_d = 1'b0;
                    timeout_d  = 1'b0;
                    state_d    = S_FEED;
                end
            end

            S_FEED: begin
                // The layer's ready doubles as the transfer strobe; a stall
                // simply holds the current element with no time limit.
                layer_value = buf_q[32'(idx_q) * WIDTH +: WIDTH];
                layer_valid = LAYER_READY;
                if (LAYER_OVERFLOW) begin
                    overflow_d = 1'b1;
                end
                if (LAYER_READY) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (LAYER_OVERFLOW) begin
                    overflow_d = 1'b1;
                end
                // A full set of valids wins over the timeout in the same cycle.
                if (&LAYER_VALIDS) begin
                    results_d = LAYER_VALUES;
                    state_d   = S_FINISH;
                end else if (cnt_q == CNT_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign BUSY        = (state_q != S_IDLE);
    assign DONE        = (state_q == S_FINISH);
    assign RESULTS     = results_q;
    assign OVERFLOW    = overflow_q;
    assign TIMEOUT     = timeout_q;
    assign LAYER_VALID = layer_valid;
    assign LAYER_VALUE = layer_value;

endmodule

// File: tb/tb_hidden_layer_sequencer.sv
// Testbench for hidden_layer_sequencer: directed table of passes, randomized
// passes, and a hand-written mid-pass reset sequence, all checked cycle by
// cycle against a pass-level reference model.
module tb_hidden_layer_sequencer;

    localparam int NI = 4;
    localparam int NO = 2;
    localparam int W  = 8;
    localparam int T  = 8;

    localparam int P_FEED = 0;
    localparam int P_WAIT = 1;
    localparam int P_FIN  = 2;

    logic             CLK = 1'b0;
    logic             RSTN = 1'b1;
    logic             START = 1'b0;
    logic [NI*W-1:0]  VALUES_IN = '0;
    logic             BUSY;
    logic             DONE;
    logic [NO*W-1:0]  RESULTS;
    logic             OVERFLOW;
    logic             TIMEOUT;
    logic             LAYER_READY = 1'b0;
    logic [W-1:0]     LAYER_VALUE;
    logic             LAYER_VALID;
    logic [NO*W-1:0]  LAYER_VALUES = '0;
    logic [NO-1:0]    LAYER_VALIDS = '0;
    logic             LAYER_OVERFLOW = 1'b0;

    hidden_layer_sequencer #(
        .NUM_INPUTS    (NI),
        .NUM_OUTPUTS   (NO),
        .WIDTH         (W),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK           (CLK),
        .RSTN          (RSTN),
        .START         (START),
        .VALUES_IN     (VALUES_IN),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .RESULTS       (RESULTS),
        .OVERFLOW      (OVERFLOW),
        .TIMEOUT       (TIMEOUT),
        .LAYER_READY   (LAYER_READY),
        .LAYER_VALUE   (LAYER_VALUE),
        .LAYER_VALID   (LAYER_VALID),
        .LAYER_VALUES  (LAYER_VALUES),
        .LAYER_VALIDS  (LAYER_VALIDS),
        .LAYER_OVERFLOW(LAYER_OVERFLOW)
    );

    always #5 CLK = ~CLK;

    // One pass description: stimulus knobs plus table expectations
    // (exp_done < 0 means the pass is checked by the model only).
    typedef struct {
        logic [NI*W-1:0] vals;
        logic [NO*W-1:0] lres;
        int              rmode;   // 0 always ready, 1 fixed pattern, 2 random
        int              vdelay;  // WAIT cycle (1-based) where all valids rise; 0 never
        int              ovf_at;  // pass cycle with LAYER_OVERFLOW pulse; 0 none
        bit              noise;   // random START/VALUES_IN while busy
        int              exp_done;
        bit              exp_to;
        bit              exp_ov;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Status the DUT should hold after the most recent pass.
    logic [NO*W-1:0] res_exp = '0;
    bit              to_exp  = 1'b0;
    bit              ov_exp  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one pass starting in IDLE (first IDLE cycle after any previous
    // FINISH). Entered and left at posedge+1.
    task automatic run_pass(input vec_t v);
        bit          pat [7];
        int          phase;
        int          n;
        int          wn;
        bit          ready;
        bit          ovf;
        bit          allv;
        bit          ov_seen;
        bit          to;
        logic [W-1:0] elem;

        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        // Cycle 0: START accepted in IDLE; layer inputs are noise here.
        START          = 1'b1;
        VALUES_IN      = v.vals;
        LAYER_READY    = 1'($urandom_range(0, 1));
        LAYER_OVERFLOW = 1'b0;
        LAYER_VALIDS   = '1;
        LAYER_VALUES   = 16'($urandom);
        @(negedge CLK);
        check("idle_busy", BUSY, 0);
        check("idle_done", DONE, 0);
        check("idle_timeout", TIMEOUT, to_exp);
        check("idle_overflow", OVERFLOW, ov_exp);
        check("idle_results", RESULTS, res_exp);
        check("idle_layer_valid", LAYER_VALID, 0);
        check("idle_layer_value", LAYER_VALUE, 0);
        @(posedge CLK);
        #1;

        phase   = P_FEED;
        n       = 0;
        wn      = 0;
        ov_seen = 1'b0;
        to      = 1'b0;

        for (int c = 1; c <= 300; c++) begin
            case (v.rmode)
                0:       ready = 1'b1;
                1:       ready = (c <= 7) ? pat[c-1] : 1'b1;
                default: ready = 1'($urandom_range(0, 1));
            endcase
            ovf  = (c == v.ovf_at);
            allv = (phase == P_WAIT) && (v.vdelay > 0) && (wn >= v.vdelay);

            LAYER_READY    = ready;
            LAYER_OVERFLOW = ovf;
            LAYER_VALIDS   = allv ? 2'b11 : 2'b01;
            LAYER_VALUES   = allv ? v.lres : ~v.lres;
            START          = v.noise ? 1'($urandom_range(0, 1)) : 1'b0;
            VALUES_IN      = v.noise ? 32'($urandom) : v.vals;

            @(negedge CLK);
            elem = (phase == P_FEED) ? v.vals[n*W +: W] : '0;
            check("busy", BUSY, 1);
            check("done", DONE, phase == P_FIN);
            check("layer_valid", LAYER_VALID, (phase == P_FEED) && ready);
            check("layer_value", LAYER_VALUE, elem);
            check("overflow", OVERFLOW, ov_seen);
            check("timeout", TIMEOUT, (phase == P_FIN) ? to : 1'b0);
            check("results", RESULTS, res_exp);

            if (phase == P_FIN) begin
                if (v.exp_done >= 0) begin
                    check("done_cycle", c, v.exp_done);
                    check("timeout_flag", TIMEOUT, v.exp_to);
                    check("overflow_flag", OVERFLOW, v.exp_ov);
                end
                to_exp = to;
                ov_exp = ov_seen;
                @(posedge CLK);
                #1;
                return;
            end

            // Reference: what the sequencer must conclude from this cycle.
            if (ovf) ov_seen = 1'b1;
            if (phase == P_FEED) begin
                if (ready) begin
                    n++;
                    if (n == NI) begin
                        phase = P_WAIT;
                        wn    = 1;
                    end
                end
            end else begin
                if (allv) begin
                    res_exp = v.lres;
                    phase   = P_FIN;
                end else if (wn == T) begin
                    to    = 1'b1;
                    phase = P_FIN;
                end else begin
                    wn++;
                end
            end
            @(posedge CLK);
            #1;
        end
        total++;
        bad++;
        $display("FAIL pass_budget: got no DONE within 300 cycles expected DONE");
    endtask

    vec_t vecs [9];
    vec_t rv;

    initial begin
        // Directed passes. Timeline with ready held high: START cycle 0,
        // transfers 1..4, WAIT from cycle 5, DONE one cycle after the deciding
        // WAIT cycle; timeout decides in the 8th WAIT cycle.
        vecs[0] = '{32'h807F_F010, 16'hE122, 0, 3,  0, 1'b0,  8, 1'b0, 1'b0}; // nominal
        vecs[1] = '{32'h4433_2211, 16'h5AA5, 1, 1,  0, 1'b0,  9, 1'b0, 1'b0}; // backpressure
        vecs[2] = '{32'hDEAD_BEEF, 16'h1234, 0, 0,  0, 1'b0, 13, 1'b1, 1'b0}; // timeout
        vecs[3] = '{32'h0102_0304, 16'h7F80, 0, 2,  2, 1'b0,  7, 1'b0, 1'b1}; // overflow in FEED
        vecs[4] = '{32'hA5A5_5A5A, 16'h0FF0, 0, 1,  0, 1'b0,  6, 1'b0, 1'b0}; // minimum pass, clears OVERFLOW
        vecs[5] = '{32'h1122_3344, 16'hC33C, 0, 8,  0, 1'b0, 13, 1'b0, 1'b0}; // valids at the limit
        vecs[6] = '{32'h5566_7788, 16'hBEEF, 0, 9, 12, 1'b0, 13, 1'b1, 1'b1}; // one cycle late, overflow in WAIT
        vecs[7] = '{32'h99AA_BBCC, 16'h6006, 0, 1,  6, 1'b1,  6, 1'b0, 1'b0}; // overflow in FINISH ignored
        vecs[8] = '{32'hF00F_E11E, 16'h8001, 1, 4,  0, 1'b1, 12, 1'b0, 1'b0}; // START noise while busy

        // Power-on reset.
        #1 RSTN = 1'b0;
        LAYER_READY  = 1'b1;
        LAYER_VALIDS = '1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("por_busy", BUSY, 0);
        check("por_done", DONE, 0);
        check("por_layer_valid", LAYER_VALID, 0);
        check("por_layer_value", LAYER_VALUE, 0);
        check("por_overflow", OVERFLOW, 0);
        check("por_timeout", TIMEOUT, 0);
        check("por_results", RESULTS, 0);
        RSTN = 1'b1;
        @(posedge CLK);
        #1;

        foreach (vecs[i]) run_pass(vecs[i]);

        for (int k = 0; k < 20; k++) begin
            rv.vals     = 32'($urandom);
            rv.lres     = 16'($urandom);
            rv.rmode    = 2;
            rv.vdelay   = $urandom_range(0, 10);
            rv.ovf_at   = $urandom_range(0, 15);
            rv.noise    = 1'($urandom_range(0, 1));
            rv.exp_done = -1;
            rv.exp_to   = 1'b0;
            rv.exp_ov   = 1'b0;
            run_pass(rv);
        end

        // Reset in the middle of WAIT with OVERFLOW already set.
        START          = 1'b1;
        VALUES_IN      = 32'hA1B2_C3D4;
        LAYER_READY    = 1'b1;
        LAYER_OVERFLOW = 1'b0;
        LAYER_VALIDS   = 2'b01;
        @(posedge CLK);
        #1;
        START          = 1'b0;
        LAYER_OVERFLOW = 1'b1;
        @(posedge CLK);
        #1;
        LAYER_OVERFLOW = 1'b0;
        repeat (5) @(posedge CLK);
        #2;
        check("pre_rst_busy", BUSY, 1);
        check("pre_rst_overflow", OVERFLOW, 1);
        check("pre_rst_layer_valid", LAYER_VALID, 0);
        RSTN = 1'b0;
        #1;
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_layer_valid", LAYER_VALID, 0);
        check("rst_layer_value", LAYER_VALUE, 0);
        check("rst_overflow", OVERFLOW, 0);
        check("rst_timeout", TIMEOUT, 0);
        check("rst_results", RESULTS, 0);
        LAYER_VALIDS = 2'b11;
        LAYER_VALUES = 16'hFFFF;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("post_rst_busy", BUSY, 0);
            check("post_rst_results", RESULTS, 0);
            check("post_rst_layer_valid", LAYER_VALID, 0);
        end
        @(posedge CLK);
        #1;
        res_exp = '0;
        to_exp  = 1'b0;
        ov_exp  = 1'b0;
        run_pass(vecs[0]);

        START = 1'b0;
        @(negedge CLK);
        check("final_busy", BUSY, 0);
        check("final_results", RESULTS, 16'hE122);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
